// File: rtl/pipelined_block_cla_add.sv
// pipelined_block_cla_add
// N-bit add/subtract built from B-bit carry-lookahead blocks, BPS blocks per
// pipeline stage. Each stage resolves one W = B*BPS bit slice. A single word
// per stage carries the not-yet-used operand bits together with the sum
// bits already resolved, so the sum arrives deskewed at the last stage.
// The whole pipeline advances together under a valid/ready handshake.
module pipelined_block_cla_add #(
  parameter int N   = 32,
  parameter int B   = 4,
  parameter int BPS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co,
  output logic         ov
);

  localparam int W      = B * BPS;
  localparam int STAGES = N / W;

  // One W-bit slice: BPS blocks of B bits. Block P/G terms feed a group
  // lookahead that produces every block carry-in directly from cin; each
  // bit carry is then formed from its own block carry-in.
  // Returns {carry out of the slice, W sum bits}.
  function automatic logic [W:0] cla_slice(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         cin);
    logic [W-1:0]   p;
    logic [W-1:0]   g;
    logic [W-1:0]   s;
    logic [BPS-1:0] bp;
    logic [BPS-1:0] bg;
    logic [BPS:0]   bc;
    logic           gt;
    logic           pt;
    p = x ^ y;
    g = x & y;
    // Block propagate / generate over B bits
    for (int j = 0; j < BPS; j++) begin
      gt = 1'b0;
      pt = 1'b1;
      for (int i = 0; i < B; i++) begin
        gt = g[j*B+i] | (p[j*B+i] & gt);
        pt = pt & p[j*B+i];
      end
      bg[j] = gt;
      bp[j] = pt;
    end
    // Group lookahead: block carry j+1 expanded back to cin
    bc[0] = cin;
    for (int j = 0; j < BPS; j++) begin
      gt = bg[j];
      pt = bp[j];
      for (int m = j - 1; m >= 0; m--) begin
        gt = gt | (pt & bg[m]);
        pt = pt & bp[m];
      end
      bc[j+1] = gt | (pt & cin);
    end
    // Bit carries inside each block expanded back to the block carry-in
    for (int j = 0; j < BPS; j++) begin
      for (int i = 0; i < B; i++) begin
        gt = 1'b0;
        pt = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          gt = gt | (pt & g[j*B+m]);
          pt = pt & p[j*B+m];
        end
        s[j*B+i] = p[j*B+i] ^ (gt | (pt & bc[j]));
      end
    end
    return {bc[BPS], s};
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] load_s;
  logic              adv_s;
  logic              ov_d;
  logic              ov_q;

  // Everything moves when the output register is empty or being drained
  assign adv_s    = ~valid_q[STAGES-1] | out_ready;
  assign in_ready = adv_s;
  assign load_s   = vin_s & {STAGES{adv_s}};

  // Valid bit presented to each stage's input
  if (STAGES == 1) begin : g_vin_one
    assign vin_s = in_valid;
  end else begin : g_vin_chain
    assign vin_s = {valid_q[STAGES-2:0], in_valid};
  end

  // Stage valid bits shift together on every advance; bubbles travel as 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv_s) begin
      valid_q <= vin_s;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Incoming word: {b remainder, a remainder, resolved sum bits}
    localparam int PW = 2*N - k*W;
    localparam int OW = 2*N - (k+1)*W;
    localparam int LO = k*W;

    logic [PW-1:0] in_word_s;
    logic          cin_s;
    logic [W-1:0]  x_s;
    logic [W-1:0]  y_s;
    logic [W:0]    res_s;
    logic [OW-1:0] st_d;
    logic [OW-1:0] st_q;
    logic          carry_q;

    if (k == 0) begin : g_src
      // Subtract folds into the add: invert b and the carry-in
      assign in_word_s = {b ^ {N{sub}}, a};
      assign cin_s     = ci ^ sub;
    end else begin : g_src
      assign in_word_s = g_stage[k-1].st_q;
      assign cin_s     = g_stage[k-1].carry_q;
    end

    assign x_s   = in_word_s[LO +: W];
    assign y_s   = in_word_s[N +: W];
    assign res_s = cla_slice(x_s, y_s, cin_s);

    if (k == STAGES - 1) begin : g_last
      if (k == 0) begin : g_pack
        assign st_d = res_s[W-1:0];
      end else begin : g_pack
        assign st_d = {res_s[W-1:0], in_word_s[LO-1:0]};
      end
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit
      assign ov_d = x_s[W-1] ^ y_s[W-1] ^ res_s[W-1] ^ res_s[W];
    end else begin : g_mid
      if (k == 0) begin : g_pack
        assign st_d = {in_word_s[PW-1:N+W], in_word_s[N-1:W], res_s[W-1:0]};
      end else begin : g_pack
        assign st_d = {in_word_s[PW-1:N+W], in_word_s[N-1:LO+W],
                       res_s[W-1:0], in_word_s[LO-1:0]};
      end
    end

    // Capture this stage's word and slice carry when a valid item advances
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q    <= '0;
        carry_q <= 1'b0;
      end else if (load_s[k]) begin
        st_q    <= st_d;
        carry_q <= res_s[W];
      end
    end
  end

  // Overflow flag for the item captured by the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else if (load_s[STAGES-1]) begin
      ov_q <= ov_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign c         = g_stage[STAGES-1].st_q;
  assign co        = g_stage[STAGES-1].carry_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_pipelined_block_cla_add.sv
// Directed and scoreboard bench for pipelined_block_cla_add: default
// configuration plus N=16 (STAGES=1 and STAGES=4) and N=64 instances.
module tb_pipelined_block_cla_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, ci, sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, co, ov;
  logic [31:0] c;

  logic        s_or;
  logic        s16_iv, s16_ci, s16_sub;
  logic [15:0] s16_a, s16_b;
  logic        s16x_ir, s16x_ov_valid, s16x_co, s16x_ov;
  logic [15:0] s16x_c;
  logic        s16y_ir, s16y_ov_valid, s16y_co, s16y_ov;
  logic [15:0] s16y_c;
  logic        s64_iv, s64_ci, s64_sub;
  logic [63:0] s64_a, s64_b;
  logic        s64_ir, s64_ov_valid, s64_co, s64_ov;
  logic [63:0] s64_c;

  int checks = 0;
  int errors = 0;

  pipelined_block_cla_add #(.N(32), .B(4), .BPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .co(co), .ov(ov));

  pipelined_block_cla_add #(.N(16), .B(4), .BPS(4)) dut16x (
    .clk(clk), .rst_n(rst_n), .in_valid(s16_iv), .in_ready(s16x_ir),
    .a(s16_a), .b(s16_b), .ci(s16_ci), .sub(s16_sub), .out_valid(s16x_ov_valid),
    .out_ready(s_or), .c(s16x_c), .co(s16x_co), .ov(s16x_ov));

  pipelined_block_cla_add #(.N(16), .B(4), .BPS(1)) dut16y (
    .clk(clk), .rst_n(rst_n), .in_valid(s16_iv), .in_ready(s16y_ir),
    .a(s16_a), .b(s16_b), .ci(s16_ci), .sub(s16_sub), .out_valid(s16y_ov_valid),
    .out_ready(s_or), .c(s16y_c), .co(s16y_co), .ov(s16y_ov));

  pipelined_block_cla_add #(.N(64), .B(8), .BPS(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(s64_iv), .in_ready(s64_ir),
    .a(s64_a), .b(s64_b), .ci(s64_ci), .sub(s64_sub), .out_valid(s64_ov_valid),
    .out_ready(s_or), .c(s64_c), .co(s64_co), .ov(s64_ov));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set, then wait (bounded) for its result.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic civ, input logic subv,
                       output int lat, output logic [33:0] res,
                       output logic vld_after);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = av; b = bv; ci = civ; sub = subv;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    res = {c, co, ov};
    step();
    vld_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c: got %h want 00000000", c); end
    checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL reset_co_ov: got %b want 00", {co, ov}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vci [3];
    logic [33:0] ex [3];
    logic [33:0] res;
    int          lat;
    logic        vld;
    va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
    vb = '{32'h0000_0000, 32'h0000_0001, 32'h9ABC_DEF0};
    vci = '{1'b1, 1'b0, 1'b0};
    ex = '{{32'h0000_0000, 2'b10}, {32'h8000_0000, 2'b01}, {32'hACF1_3568, 2'b00}};
    for (int k = 0; k < 3; k++) begin
      issue(va[k], vb[k], vci[k], 1'b0, lat, res, vld);
      checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency: got %0d want 4", k, lat); end
      checks++; if (res !== ex[k]) begin errors++; $display("FAIL add%0d_result: got c=%h co=%b ov=%b want c=%h co=%b ov=%b", k, res[33:2], res[1], res[0], ex[k][33:2], ex[k][1], ex[k][0]); end
      checks++; if (vld !== 1'b0) begin errors++; $display("FAIL add%0d_single_valid: got %b want 0", k, vld); end
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vci [3];
    logic [33:0] ex [3];
    logic [33:0] res;
    int          lat;
    logic        vld;
    va = '{32'h0000_0005, 32'h8000_0000, 32'h0000_0009};
    vb = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0004};
    vci = '{1'b0, 1'b0, 1'b1};
    ex = '{{32'hFFFF_FFFE, 2'b00}, {32'h7FFF_FFFF, 2'b11}, {32'h0000_0004, 2'b10}};
    for (int k = 0; k < 3; k++) begin
      issue(va[k], vb[k], vci[k], 1'b1, lat, res, vld);
      checks++; if (lat !== 4) begin errors++; $display("FAIL sub%0d_latency: got %0d want 4", k, lat); end
      checks++; if (res !== ex[k]) begin errors++; $display("FAIL sub%0d_result: got c=%h co=%b ov=%b want c=%h co=%b ov=%b", k, res[33:2], res[1], res[0], ex[k][33:2], ex[k][1], ex[k][0]); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   recv = 0;
    int   stall = 0;
    int   cyc = 0;
    logic extra = 1'b0;
    ci = 1'b0; sub = 1'b0;
    while (recv < 8 && cyc < 60) begin
      if (out_valid === 1'b1 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 8);
      a = 32'(sent);
      b = 32'h10 * 32'(sent);
      #1;
      if (out_ready === 1'b0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
        checks++; if (c !== 32'h11 * 32'(recv)) begin errors++; $display("FAIL b2b_stall_hold: got %h want %h", c, 32'h11 * 32'(recv)); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++; if (c !== 32'h11 * 32'(recv)) begin errors++; $display("FAIL b2b_result%0d: got %h want %h", recv, c, 32'h11 * 32'(recv)); end
        recv++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
      cyc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (recv !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", recv); end
    checks++; if (stall !== 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall); end
    repeat (6) begin
      if (out_valid !== 1'b0) extra = 1'b1;
      step();
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate: got extra out_valid want none"); end
  endtask

  task automatic test_random();
    logic [33:0] q [$];
    logic [33:0] exp;
    logic [31:0] ra, rb, bb;
    logic [32:0] full;
    logic        rci, rsub;
    logic        pend = 1'b0;
    int          n_in = 0;
    int          n_out = 0;
    int          cyc = 0;
    while (n_out < 10000 && cyc < 60000) begin
      if (!pend && n_in < 10000 && $urandom_range(0, 3) != 0) begin
        ra = $urandom; rb = $urandom;
        rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      in_valid = pend;
      a = ra; b = rb; ci = rci; sub = rsub;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got c=%h with empty scoreboard want no result", c);
        end else begin
          exp = q.pop_front();
          if ({c, co, ov} !== exp) begin errors++; $display("FAIL rand_result%0d: got c=%h co=%b ov=%b want c=%h co=%b ov=%b", n_out, c, co, ov, exp[33:2], exp[1], exp[0]); end
        end
        n_out++;
      end
      if (pend && in_ready === 1'b1) begin
        bb = rsub ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + {32'h0, rsub ? ~rci : rci};
        q.push_back({full[31:0], full[32], (ra[31] == bb[31]) && (full[31] != ra[31])});
        pend = 1'b0;
        n_in++;
      end
      cyc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (n_out !== 10000 || q.size() != 0) begin errors++; $display("FAIL rand_count: got %0d results %0d pending want 10000 and 0", n_out, q.size()); end
  endtask

  task automatic test_async_reset();
    logic [33:0] res;
    int          lat;
    logic        vld;
    logic        stale = 1'b0;
    out_ready = 1'b1;
    ci = 1'b0; sub = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      a = (k == 0) ? 32'hC000_0000 : 32'hFFFF_FFFF;
      b = (k == 0) ? 32'h9000_0000 : 32'h0000_0002;
      step();
    end
    in_valid = 1'b0;
    checks++; if ({out_valid, c, co, ov} !== {1'b1, 32'h5000_0000, 2'b11}) begin errors++; $display("FAIL arst_prefill: got v=%b c=%h co=%b ov=%b want v=1 c=50000000 co=1 ov=1", out_valid, c, co, ov); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if ({c, co, ov} !== 34'h0) begin errors++; $display("FAIL arst_outputs: got c=%h co=%b ov=%b want all 0", c, co, ov); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) begin
      step();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL arst_stale: got stale out_valid want none"); end
    issue(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, lat, res, vld);
    checks++; if (lat !== 4) begin errors++; $display("FAIL arst_new_latency: got %0d want 4", lat); end
    checks++; if (res !== {32'h0000_0008, 2'b00}) begin errors++; $display("FAIL arst_new_result: got c=%h want 00000008", res[33:2]); end
  endtask

  task automatic test_sweep16();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vci [3];
    logic        vsb [3];
    logic [17:0] ex [3];
    logic [17:0] rx, ry;
    int          lx, ly;
    va = '{16'hFFFF, 16'h7FFF, 16'h8000};
    vb = '{16'h0000, 16'h0001, 16'h0001};
    vci = '{1'b1, 1'b0, 1'b0};
    vsb = '{1'b0, 1'b0, 1'b1};
    ex = '{{16'h0000, 2'b10}, {16'h8000, 2'b01}, {16'h7FFF, 2'b11}};
    for (int k = 0; k < 3; k++) begin
      s16_iv = 1'b1; s16_a = va[k]; s16_b = vb[k]; s16_ci = vci[k]; s16_sub = vsb[k];
      step();
      s16_iv = 1'b0;
      lx = 0; ly = 0; rx = '0; ry = '0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        if (s16x_ov_valid === 1'b1 && lx == 0) begin lx = cyc; rx = {s16x_c, s16x_co, s16x_ov}; end
        if (s16y_ov_valid === 1'b1 && ly == 0) begin ly = cyc; ry = {s16y_c, s16y_co, s16y_ov}; end
        step();
      end
      checks++; if (lx !== 1) begin errors++; $display("FAIL n16s1_%0d_latency: got %0d want 1", k, lx); end
      checks++; if (rx !== ex[k]) begin errors++; $display("FAIL n16s1_%0d_result: got %h want %h", k, rx, ex[k]); end
      checks++; if (ly !== 4) begin errors++; $display("FAIL n16s4_%0d_latency: got %0d want 4", k, ly); end
      checks++; if (ry !== ex[k]) begin errors++; $display("FAIL n16s4_%0d_result: got %h want %h", k, ry, ex[k]); end
    end
  endtask

  task automatic test_sweep64();
    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic        vci [3];
    logic        vsb [3];
    logic [65:0] ex [3];
    logic [65:0] r;
    int          l;
    va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vb = '{64'h0, 64'h1, 64'h1};
    vci = '{1'b1, 1'b0, 1'b0};
    vsb = '{1'b0, 1'b0, 1'b1};
    ex = '{{64'h0, 2'b10}, {64'h8000_0000_0000_0000, 2'b01}, {64'h7FFF_FFFF_FFFF_FFFF, 2'b11}};
    for (int k = 0; k < 3; k++) begin
      s64_iv = 1'b1; s64_a = va[k]; s64_b = vb[k]; s64_ci = vci[k]; s64_sub = vsb[k];
      step();
      s64_iv = 1'b0;
      l = 0; r = '0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        if (s64_ov_valid === 1'b1 && l == 0) begin l = cyc; r = {s64_c, s64_co, s64_ov}; end
        step();
      end
      checks++; if (l !== 4) begin errors++; $display("FAIL n64_%0d_latency: got %0d want 4", k, l); end
      checks++; if (r !== ex[k]) begin errors++; $display("FAIL n64_%0d_result: got %h want %h", k, r, ex[k]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = 32'h0; b = 32'h0; ci = 1'b0; sub = 1'b0;
    s_or = 1'b1;
    s16_iv = 1'b0; s16_a = 16'h0; s16_b = 16'h0; s16_ci = 1'b0; s16_sub = 1'b0;
    s64_iv = 1'b0; s64_a = 64'h0; s64_b = 64'h0; s64_ci = 1'b0; s64_sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_sweep16();
    test_sweep64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_block_cla_add.md
Name: pipelined_block_cla_add

Overview:
- Parametrised, pipelined successor to the team's structural block carry-lookahead adder.
- Splits an N-bit add/subtract into B-bit carry-lookahead blocks, with BPS blocks resolved per pipeline stage.
- Inter-stage carry, skewed operands and sum bits are registered, and the result is deskewed at the output.
- Sits in the FixedPointArithmetic datapath behind a valid/ready stream interface, with signed-overflow flag generation.

Parameters:
- N, 32, datapath width in bits; must be divisible by B*BPS.
- B, 4, bits per carry-lookahead block (block P/G computed over B bits, ripple-free within the block).
- BPS, 2, blocks per pipeline stage; STAGES = N/(B*BPS), W = B*BPS bits resolved per stage.

Ports:
- clk  input  1  Clock, all state updates on rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- in_valid  input  1  Operands valid.
- in_ready  output  1  Block accepts operands this cycle.
- a  input  N  Operand A.
- b  input  N  Operand B.
- ci  input  1  Carry in (borrow in when sub=1).
- sub  input  1  0: c = a + b + ci. 1: c = a + ~b + ~ci, i.e. a - b - ci.
- out_valid  output  1  Result valid.
- out_ready  input  1  Downstream accepts the result.
- c  output  N  Result.
- co  output  1  Raw carry out of bit N-1 (for sub: 1 = no borrow).
- ov  output  1  Signed overflow = carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid bits, c, co, ov cleared to 0; out_valid=0. Reset mid-operation discards all in-flight results. First acceptance is possible in the cycle after rst_n deasserts.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, purely combinational from out_valid and out_ready.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - When adv=0 the whole pipeline holds and every register keeps its value.
  - Stage valid bits shift by one per adv cycle; bubbles (in_valid=0) propagate as valid=0.
- Stage 0, on transfer:
  - Captures b' = b XOR {N{sub}} and cin = ci XOR sub.
  - Resolves bits [W-1:0] using the BPS block P/G terms plus a W-bit group lookahead.
  - Registers sum slice 0, carry out of slice 0, and the upper operand slices.
- Stage k (k=1..STAGES-1):
  - Resolves bits [k*W +: W] from the registered carry and the registered operand slices.
  - Lower sum slices travel in a deskew shift register so all N bits align at the final stage.
- Final stage registers c, co and ov. ov is derived from the bit N-1 carry-in and carry-out of the last block.
- Latency: a transfer in cycle t gives out_valid=1 in cycle t+STAGES when no stall occurs. Throughput is 1 result per cycle with out_ready held at 1.
- Stalls: each cycle out_valid=1 && out_ready=0 adds one cycle of latency to every in-flight item. Results are never dropped, duplicated or reordered.
- Arithmetic is modulo 2^N, with no saturation.
- Simultaneous events:
  - Input and output transfer in the same cycle is legal and the pipeline stays full.
  - in_valid=1 while in_ready=0: the operands are not consumed, and the source must hold them.
- STAGES=1 is legal: a single registered stage, latency 1.

Test Plan:
- N=32,B=4,BPS=2 → STAGES=4. a=0xFFFFFFFF, b=0x00000000, ci=1, sub=0, out_ready=1 → 4 cycles later c=0x00000000, co=1, ov=0, out_valid=1 for exactly one cycle. This exercises the full carry chain across all stages.
- a=0x7FFFFFFF, b=0x00000001, ci=0, sub=0 → c=0x80000000, co=0, ov=1.
- a=5, b=7, ci=0, sub=1 → c=0xFFFFFFFE, co=0, ov=0.
  - Then a=0x80000000, b=1, ci=0, sub=1 → c=0x7FFFFFFF, co=1, ov=1.
  - Then a=9, b=4, ci=1, sub=1 → c=4, co=1.
- Stream of 8 back-to-back transfers (a=i, b=0x10*i), with out_ready=0 for 3 cycles once out_valid rises:
  - in_ready drops to 0 in those cycles and the pipeline holds.
  - All 8 results appear in order, none lost or duplicated.
  - A random-operand scoreboard against a behavioural model checks 10k transfers with random in_valid and out_ready.
- Fill the pipeline with 4 items, then pulse rst_n=0 for one cycle asynchronously between clock edges:
  - out_valid, c, co and ov read 0 immediately, with no clock edge needed.
  - No stale result appears afterwards.
  - A new transfer after release completes in 4 cycles.
- Parameter sweep:
  - N=16,B=4,BPS=1 (STAGES=4) and N=16,B=4,BPS=4 (STAGES=1, latency 1).
  - N=64,B=8,BPS=2 (STAGES=4).
  - The same directed overflow and carry vectors, scaled to N, must pass in each configuration.
